// File: rtl/shift_seq_pkg.sv
// Shared constants for the multi-cycle shift/rotate unit: FSM state
// encodings and the {LA,LR} mode encodings.
package shift_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    // {LA,LR}: LA selects rotate, LR selects right.
    localparam logic [1:0] MODE_ROR = 2'b11;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_SHL = 2'b00;

    typedef struct packed {
        logic la;
        logic lr;
    } mode_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; the carry is the bit that
// leaves the word on this step.
import shift_seq_pkg::*;

module shift_step (
    input  logic [7:0] y,
    input  logic       la,
    input  logic       lr,
    output logic [7:0] y_next,
    output logic       c_next
);

    always_comb begin
        y_next = y;
        c_next = 1'b0;
        case ({la, lr})
            MODE_ROR: begin
                y_next = {y[0], y[7:1]};
                c_next = y[0];
            end
            MODE_ROL: begin
                y_next = {y[6:0], y[7]};
                c_next = y[7];
            end
            MODE_SHR: begin
                y_next = {1'b0, y[7:1]};
                c_next = y[0];
            end
            default: begin
                y_next = {y[6:0], 1'b0};
                c_next = y[7];
            end
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate unit: one bit position per clock, driven through
// a START/BUSY/DONE handshake.
import shift_seq_pkg::*;

module shift_seq (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] A,
    input  logic [2:0] CNT,
    input  logic       LA,
    input  logic       LR,
    input  logic       START,
    output logic [7:0] Y,
    output logic       C,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] state
);

    // Handshake: START is taken only on an edge where BUSY=0; operands and
    // mode are latched then. DONE pulses for one cycle when Y/C are final.
    logic [2:0] rem;
    mode_t      mode;
    logic [7:0] y_step;
    logic       c_step;

    shift_step u_step (
        .y      (Y),
        .la     (mode.la),
        .lr     (mode.lr),
        .y_next (y_step),
        .c_next (c_step)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= ST_IDLE;
            Y     <= 8'h00;
            C     <= 1'b0;
            rem   <= 3'd0;
            mode  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        Y       <= A;
                        C       <= 1'b0;
                        rem     <= CNT;
                        mode.la <= LA;
                        mode.lr <= LR;
                        state   <= (CNT == 3'd0) ? ST_FIN : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    Y   <= y_step;
                    C   <= c_step;
                    rem <= rem - 3'd1;
                    if (rem == 3'd1) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state != ST_IDLE);
    assign DONE = (state == ST_FIN);

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: directed and random operations, a reference model
// built from shift arithmetic, and a DONE-driven scoreboard.
module tb_shift_seq;

    logic       CLK;
    logic       RESETN;
    logic [7:0] A;
    logic [2:0] CNT;
    logic       LA;
    logic       LR;
    logic       START;
    logic [7:0] Y;
    logic       C;
    logic       BUSY;
    logic       DONE;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Expected entry: {done_cycle[22:0], c, y}
    logic [31:0] exp_q[$];

    shift_seq dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .A      (A),
        .CNT    (CNT),
        .LA     (LA),
        .LR     (LR),
        .START  (START),
        .Y      (Y),
        .C      (C),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .state  (state)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result after k single-bit steps: {c, y}
    function automatic logic [8:0] model(input logic [7:0] a, input int k,
                                         input logic la, input logic lr);
        logic [7:0] y;
        logic       c;
        if (k == 0) return {1'b0, a};
        if (lr) begin
            y = la ? ((a >> k) | (a << (8 - k))) : (a >> k);
            c = a[k-1];
        end else begin
            y = la ? ((a << k) | (a >> (8 - k))) : (a << k);
            c = a[8-k];
        end
        return {c, y};
    endfunction

    // Driver: launch one operation, then follow it while BUSY, checking the
    // intermediate Y/C and the BUSY length; optionally poke START mid-op.
    task automatic run_op(input logic [7:0] a, input logic [2:0] n,
                          input logic la, input logic lr, input bit poke);
        int         t0;
        int         j;
        int         k;
        logic [8:0] r;
        @(negedge CLK);
        A = a; CNT = n; LA = la; LR = lr; START = 1'b1;
        @(posedge CLK);
        #1;
        t0 = cyc;
        START = 1'b0;
        A = 8'($urandom); CNT = 3'($urandom); LA = 1'($urandom); LR = 1'($urandom);
        r = model(a, int'(n), la, lr);
        exp_q.push_back({23'(t0 + int'(n)), r});
        for (j = 0; j < 20; j++) begin
            @(negedge CLK);
            if (!BUSY) break;
            k = (j < int'(n)) ? j : int'(n);
            r = model(a, k, la, lr);
            check("step_y", {24'd0, Y}, {24'd0, r[7:0]});
            check("step_c", {31'd0, C}, {31'd0, r[8]});
            if (poke && j == 0) begin
                START = 1'b1;
                A = 8'hFF;
                CNT = 3'd7;
            end else begin
                START = 1'b0;
            end
        end
        START = 1'b0;
        check("busy_len", 32'(j), 32'(int'(n) + 1));
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        logic [31:0] e;
        if (RESETN && DONE) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got DONE with empty queue at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), {9'd0, e[31:9]});
                check("done_y", {24'd0, Y}, {24'd0, e[7:0]});
                check("done_c", {31'd0, C}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        RESETN = 1'b0;
        A = 8'h00; CNT = 3'd0; LA = 1'b0; LR = 1'b0; START = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_y", {24'd0, Y}, 32'h0);
        check("rst_c", {31'd0, C}, 32'h0);
        check("rst_busy", {31'd0, BUSY}, 32'h0);
        check("rst_done", {31'd0, DONE}, 32'h0);
        RESETN = 1'b1;
        @(negedge CLK);

        // Directed cases
        run_op(8'h81, 3'd1, 1'b1, 1'b1, 1'b0);
        run_op(8'h96, 3'd3, 1'b0, 1'b0, 1'b0);
        run_op(8'h96, 3'd7, 1'b1, 1'b0, 1'b0);
        run_op(8'h5A, 3'd0, 1'b1, 1'b0, 1'b0);
        run_op(8'h01, 3'd2, 1'b0, 1'b1, 1'b0);
        run_op(8'h3C, 3'd4, 1'b0, 1'b1, 1'b1);
        run_op(8'hC3, 3'd0, 1'b0, 1'b0, 1'b1);

        // Held result in IDLE
        repeat (3) @(negedge CLK);
        check("hold_y", {24'd0, Y}, 32'h0000_00C3);
        check("hold_c", {31'd0, C}, 32'h0);

        // Reset in the middle of a shift
        @(negedge CLK);
        A = 8'hA5; CNT = 3'd5; LA = 1'b0; LR = 1'b0; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (2) @(negedge CLK);
        #2 RESETN = 1'b0;
        #1;
        check("abort_y", {24'd0, Y}, 32'h0);
        check("abort_c", {31'd0, C}, 32'h0);
        check("abort_busy", {31'd0, BUSY}, 32'h0);
        check("abort_done", {31'd0, DONE}, 32'h0);
        @(negedge CLK);
        RESETN = 1'b1;
        run_op(8'h96, 3'd3, 1'b0, 1'b0, 1'b0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom),
                   1'($urandom), bit'($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge CLK);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete by %0t", $time);
        n_tests++;
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
